// File: rtl/countdown_ctrl_pkg.sv
// countdown_ctrl_pkg
// Shared types and constants for the countdown controller.
//   state_t        : controller states (IDLE, ARMED, RUN, PAUSED, DONE)
//   DEF_WIDTH      : default count / load-value width
//   DEF_PRESCALE_W : default prescaler divider width
//   RELOAD_CNT_W   : width of the optional terminal-count counter
//                    (present only when COUNTDOWN_CTRL_RELOAD_CNT_EN is defined)
package countdown_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    RUN    = 3'd2,
    PAUSED = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int DEF_WIDTH      = 4;
  localparam int DEF_PRESCALE_W = 8;
  localparam int RELOAD_CNT_W   = 8;

endpackage

// File: rtl/countdown_prescaler.sv
// countdown_prescaler
// Divider that issues a step every prescale+1 enabled cycles.
// Ports:
//   clk      : system clock (posedge)
//   rst      : synchronous active-high reset, clears the divider
//   clr      : synchronous clear of the divider (start of a run)
//   en       : advance the divider this cycle; when low the divider holds
//   prescale : divide value, sampled every cycle
//   tick     : combinational step request (en && divider >= prescale)
module countdown_prescaler
  import countdown_ctrl_pkg::*;
#(
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] div_reg;

  // >= rather than == so that lowering prescale below the current divider
  // value mid-run produces a step immediately instead of a long wrap.
  assign tick = en && (div_reg >= prescale);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      div_reg <= '0;
    end else if (en) begin
      div_reg <= tick ? '0 : div_reg + 1'b1;
    end
  end

endmodule

// File: rtl/countdown_ctrl.sv
// countdown_ctrl
// Loadable, startable, pausable prescaled down-counter with terminal-count
// flagging and optional auto-reload.
// Ports:
//   clk, rst     : clock (posedge) and synchronous active-high reset
//   load_valid   : load request; accepted when load_valid && load_ready
//   load_value   : start value for the countdown
//   load_ready   : high in IDLE, ARMED, DONE (combinational state decode)
//   start        : level; begins a run from ARMED or restarts from DONE
//   pause        : level; freezes prescaler and count while running
//   auto_reload  : reload count from the last loaded value at terminal count
//   prescale     : step every prescale+1 cycles
//   count        : current count (registered)
//   tick         : one-cycle pulse per decrement step (registered)
//   done         : one-cycle pulse at terminal count (registered)
//   busy         : high in RUN or PAUSED (combinational state decode)
//   reload_cnt   : saturating count of done pulses, cleared by rst and by an
//                  accepted load; only present when COUNTDOWN_CTRL_RELOAD_CNT_EN
//                  is defined
module countdown_ctrl
  import countdown_ctrl_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  input  logic [WIDTH-1:0]      load_value,
  output logic                  load_ready,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  auto_reload,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  tick,
  output logic                  done,
  output logic                  busy
`ifdef COUNTDOWN_CTRL_RELOAD_CNT_EN
  ,
  output logic [RELOAD_CNT_W-1:0] reload_cnt
`endif
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic [WIDTH-1:0] reload_reg, reload_next;
  logic             tick_reg, tick_next;
  logic             done_reg, done_next;
  logic             load_fire;
  logic             pre_clr;
  logic             pre_en;
  logic             step;

  assign load_ready = (state_reg == IDLE) || (state_reg == ARMED) || (state_reg == DONE);
  assign busy       = (state_reg == RUN) || (state_reg == PAUSED);
  assign load_fire  = load_valid && load_ready;

  // The divider only advances while actively running; pause holds it.
  assign pre_en = (state_reg == RUN) && !pause;

  countdown_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .clr      (pre_clr),
    .en       (pre_en),
    .prescale (prescale),
    .tick     (step)
  );

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    reload_next = reload_reg;
    tick_next   = 1'b0;
    done_next   = 1'b0;
    pre_clr     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (load_fire) begin
          count_next  = load_value;
          reload_next = load_value;
          state_next  = ARMED;
        end
      end
      ARMED: begin
        // A load in the same cycle as start wins and keeps us armed.
        if (load_fire) begin
          count_next  = load_value;
          reload_next = load_value;
        end else if (start) begin
          pre_clr    = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (pause) begin
          state_next = PAUSED;
        end else if (step) begin
          tick_next = 1'b1;
          if (count_reg != '0) begin
            count_next = count_reg - 1'b1;
          end else begin
            // Terminal count: the step after reaching zero flags done.
            done_next = 1'b1;
            if (auto_reload) begin
              count_next = reload_reg;
            end else begin
              state_next = DONE;
            end
          end
        end
      end
      PAUSED: begin
        if (!pause) begin
          state_next = RUN;
        end
      end
      DONE: begin
        if (load_fire) begin
          count_next  = load_value;
          reload_next = load_value;
          state_next  = ARMED;
        end else if (start) begin
          count_next = reload_reg;
          pre_clr    = 1'b1;
          state_next = RUN;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      count_reg  <= '1;
      reload_reg <= '1;
      tick_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      reload_reg <= reload_next;
      tick_reg   <= tick_next;
      done_reg   <= done_next;
    end
  end

  assign count = count_reg;
  assign tick  = tick_reg;
  assign done  = done_reg;

`ifdef COUNTDOWN_CTRL_RELOAD_CNT_EN
  logic [RELOAD_CNT_W-1:0] reload_cnt_reg;

  // Loads and done pulses are mutually exclusive (loads only in
  // IDLE/ARMED/DONE, done only in RUN), so ordering here is not critical.
  always_ff @(posedge clk) begin
    if (rst || load_fire) begin
      reload_cnt_reg <= '0;
    end else if (done_next && (reload_cnt_reg != '1)) begin
      reload_cnt_reg <= reload_cnt_reg + 1'b1;
    end
  end

  assign reload_cnt = reload_cnt_reg;
`endif

endmodule

// File: tb/tb_countdown_ctrl.sv
// tb_countdown_ctrl
// Self-checking bench for countdown_ctrl: directed scenarios with arithmetic
// expectations plus randomized stimulus against a behavioural model.
// Builds with or without COUNTDOWN_CTRL_RELOAD_CNT_EN.
module tb_countdown_ctrl;

  localparam int WIDTH      = 4;
  localparam int PRESCALE_W = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  load_valid;
  logic [WIDTH-1:0]      load_value;
  logic                  load_ready;
  logic                  start;
  logic                  pause;
  logic                  auto_reload;
  logic [PRESCALE_W-1:0] prescale;
  logic [WIDTH-1:0]      count;
  logic                  tick;
  logic                  done;
  logic                  busy;
`ifdef COUNTDOWN_CTRL_RELOAD_CNT_EN
  logic [7:0]            reload_cnt;
`endif

  always #5 clk = ~clk;

  countdown_ctrl #(
    .WIDTH      (WIDTH),
    .PRESCALE_W (PRESCALE_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .load_value  (load_value),
    .load_ready  (load_ready),
    .start       (start),
    .pause       (pause),
    .auto_reload (auto_reload),
    .prescale    (prescale),
    .count       (count),
    .tick        (tick),
    .done        (done),
    .busy        (busy)
`ifdef COUNTDOWN_CTRL_RELOAD_CNT_EN
    ,
    .reload_cnt  (reload_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cycle_no = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cycle_no, got, exp);
    end
  endtask

  // Behavioural model: a "mode" word plus a cycles-since-last-step counter.
  // Modes: 0 idle, 1 armed, 2 running, 3 paused, 4 finished.
  int m_mode, m_count, m_reload, m_since, m_rc;
  bit m_tick, m_done;

  task automatic model_step();
    bit accept;
    accept = load_valid && (m_mode == 0 || m_mode == 1 || m_mode == 4);
    m_tick = 0;
    m_done = 0;
    if (rst) begin
      m_mode = 0; m_count = 15; m_reload = 15; m_since = 0; m_rc = 0;
    end else if (accept) begin
      m_count = load_value; m_reload = load_value; m_mode = 1; m_rc = 0;
      $display("load accepted value=%0d cycle=%0d", load_value, cycle_no);
    end else if (m_mode == 1 && start) begin
      m_since = 0; m_mode = 2;
    end else if (m_mode == 4 && start) begin
      m_count = m_reload; m_since = 0; m_mode = 2;
    end else if (m_mode == 3 && !pause) begin
      m_mode = 2;
    end else if (m_mode == 2 && pause) begin
      m_mode = 3;
    end else if (m_mode == 2) begin
      if (m_since >= int'(prescale)) begin
        m_since = 0;
        m_tick  = 1;
        if (m_count > 0) m_count = m_count - 1;
        else begin
          m_done = 1;
          if (m_rc < 255) m_rc = m_rc + 1;
          if (auto_reload) m_count = m_reload;
          else m_mode = 4;
        end
      end else begin
        m_since = m_since + 1;
      end
    end
  endtask

  task automatic compare_all();
    check("count", 32'(count), 32'(m_count));
    check("tick", 32'(tick), 32'(m_tick));
    check("done", 32'(done), 32'(m_done));
    check("load_ready", 32'(load_ready), 32'(m_mode == 0 || m_mode == 1 || m_mode == 4));
    check("busy", 32'(busy), 32'(m_mode == 2 || m_mode == 3));
`ifdef COUNTDOWN_CTRL_RELOAD_CNT_EN
    check("reload_cnt", 32'(reload_cnt), 32'(m_rc));
`endif
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    cycle_no++;
    compare_all();
  endtask

  task automatic do_load(input int v);
    load_valid = 1'b1;
    load_value = WIDTH'(v);
    cyc();
    load_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  int tick_at[$];
  int done_at[$];

  initial begin
    rst = 1'b1; load_valid = 1'b0; load_value = '0; start = 1'b0;
    pause = 1'b0; auto_reload = 1'b0; prescale = '0;
    cyc(); cyc();
    rst = 1'b0;
    check("reset_count", 32'(count), 32'hF);
    check("reset_ready", 32'(load_ready), 32'd1);

    // start alone in IDLE is ignored
    do_start();
    check("idle_start_busy", 32'(busy), 32'd0);

    // Basic: load 3, prescale 0
    do_load(3);
    do_start();
    for (int i = 0; i < 6; i++) cyc();
    check("basic_end_count", 32'(count), 32'd0);
    check("basic_end_busy", 32'(busy), 32'd0);

    // Prescale: load 2, prescale 3 -> ticks at +4, +8, +12, done at +12
    prescale = 8'd3;
    do_load(2);
    do_start();
    for (int k = 1; k <= 14; k++) begin
      cyc();
      if (tick) tick_at.push_back(k);
      if (done) done_at.push_back(k);
    end
    check("ps_ntick", 32'(tick_at.size()), 32'd3);
    check("ps_ndone", 32'(done_at.size()), 32'd1);
    if (tick_at.size() == 3) begin
      check("ps_tick1", 32'(tick_at[0]), 32'd4);
      check("ps_tick2", 32'(tick_at[1]), 32'd8);
      check("ps_tick3", 32'(tick_at[2]), 32'd12);
    end
    if (done_at.size() == 1) check("ps_done", 32'(done_at[0]), 32'd12);

    // Auto-reload: load 1, prescale 0
    prescale = 8'd0;
    auto_reload = 1'b1;
    do_load(1);
    do_start();
    for (int i = 0; i < 8; i++) cyc();
    check("ar_busy", 32'(busy), 32'd1);
    auto_reload = 1'b0;

    // Reset for two cycles mid-run
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    check("rst_mid_count", 32'(count), 32'hF);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_tick", 32'(tick), 32'd0);

    // Pause + held-off load
    do_load(5);
    do_start();
    prescale = 8'd1;
    load_valid = 1'b1;
    load_value = 4'd7;
    for (int i = 0; i < 3; i++) cyc();
    check("run_ready", 32'(load_ready), 32'd0);
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("pause_tick", 32'(tick), 32'd0);
    end
    pause = 1'b0;
    for (int i = 0; i < 20; i++) cyc();
    check("held_load", 32'(count), 32'd7);

    // Load and start together in ARMED: load wins
    load_value = 4'd9;
    start = 1'b1;
    cyc();
    start = 1'b0;
    load_valid = 1'b0;
    check("ld_start_count", 32'(count), 32'd9);
    check("ld_start_busy", 32'(busy), 32'd0);

    // Load 0 -> done on first tick
    prescale = 8'd0;
    do_load(0);
    do_start();
    cyc();
    check("zero_done", 32'(done), 32'd1);
    cyc();

    // Prescale lowered 10 -> 2 while divider holds 6
    prescale = 8'd10;
    do_load(15);
    do_start();
    for (int i = 0; i < 6; i++) cyc();
    prescale = 8'd2;
    cyc();
    check("lower_tick", 32'(tick), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(199) == 0);
      load_valid = ($urandom_range(7) == 0);
      load_value = WIDTH'($urandom_range(15));
      start      = ($urandom_range(3) == 0);
      pause      = ($urandom_range(5) == 0);
      if ($urandom_range(15) == 0) auto_reload = ~auto_reload;
      if ($urandom_range(9) == 0) prescale = PRESCALE_W'($urandom_range(5));
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown_ctrl.md
Name: countdown_ctrl

Overview:
- Control stage that drives a loadable, prescaled down-count and flags terminal count.
- Replaces a free-running decrement with a loaded, startable, pausable countdown.
- Sits between the command/register side, which sends load values over valid/ready, and consumers of count, tick and done.
- Single clock domain; no CDC.

Parameters:
WIDTH, 4, count and load-value width
PRESCALE_W, 8, prescaler divider width

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous, active-high reset
load_valid  input  1  load request
load_value  input  WIDTH  start value for the countdown
load_ready  output  1  load accepted when load_valid && load_ready
start  input  1  level; begins or resumes counting
pause  input  1  level; freezes prescaler and count
auto_reload  input  1  1 = reload from reload_reg at terminal count
prescale  input  PRESCALE_W  tick every prescale+1 cycles; sampled every cycle
count  output  WIDTH  current count (registered)
tick  output  1  one-cycle pulse on each decrement step
done  output  1  one-cycle pulse at terminal count
busy  output  1  high in RUN or PAUSED

Behaviour:
- Reset, synchronous, highest priority, abandons any operation:
  - state=IDLE
  - count={WIDTH{1'b1}}, reload_reg={WIDTH{1'b1}}
  - prescaler=0, tick=0, done=0, busy=0, load_ready=1
- All outputs are registered except load_ready and busy, which decode state combinationally.
- load_ready=1 in IDLE, ARMED and DONE; 0 in RUN and PAUSED. Loads offered in RUN or PAUSED are held off, not dropped.
- IDLE:
  - Accepted load: count<=load_value, reload_reg<=load_value, go to ARMED.
  - start alone is ignored.
- ARMED:
  - Accepted load overwrites count and reload_reg; stays in ARMED. A load wins over start in the same cycle.
  - start with no load: prescaler<=0, go to RUN.
- RUN, step in this priority order each cycle:
  - pause=1: go to PAUSED; no tick; prescaler and count hold.
  - Otherwise, if prescaler>=prescale: tick=1 and prescaler<=0. The >= handles prescale being lowered mid-run. prescale=0 gives a tick every cycle.
  - Otherwise prescaler<=prescaler+1.
- On a tick:
  - count!=0: count<=count-1.
  - count==0, auto_reload=1: done=1, count<=reload_reg, stay in RUN.
  - count==0, auto_reload=0: done=1, count holds 0, go to DONE.
- Latency: load N, start at cycle t, prescale P → first tick at t+1+P; done on tick N+1 at t+(N+1)(P+1). load_value=0 gives done on the first tick.
- Unsigned arithmetic; count never wraps below 0. Wrap is replaced by terminal handling.
- PAUSED: pause=0 returns to RUN next cycle, resuming the prescaler from its held value. start is ignored while paused.
- DONE:
  - Accepted load goes to ARMED with the new value.
  - start alone: count<=reload_reg, prescaler<=0, go to RUN.
- tick and done are low in every cycle not listed above.

Optional Feature:
- Macro: COUNTDOWN_CTRL_RELOAD_CNT_EN.
- Defined:
  - Adds output reload_cnt [7:0].
  - Increments on every done pulse and saturates at 8'hFF.
  - Cleared by rst and by any accepted load.
- Undefined: the port and logic are absent; all other behaviour is identical.

Decomposition:
- Package countdown_ctrl_pkg holds:
  - state enum: IDLE, ARMED, RUN, PAUSED, DONE
  - default WIDTH/PRESCALE_W constants
  - RELOAD_CNT_W=8
- One sub-module, countdown_prescaler:
  - Inputs: clk, rst, clr, en, prescale.
  - Output: tick.
  - Holds the >= compare and clear logic.
- FSM and count register stay in countdown_ctrl.

Test Plan:
- Reset: assert rst 2 cycles mid-RUN → next cycle count=4'hF, state IDLE, load_ready=1, busy=0, tick=0, done=0.
- Basic: load 3, prescale=0, start → ticks on 4 consecutive cycles; count 3,2,1,0; done pulse on the 4th tick; count stays 0; busy drops.
- Prescale: load 2, prescale=3, start at cycle t → ticks at t+4, t+8, t+12; done at t+12.
- Auto-reload: load 1, prescale=0, auto_reload=1 → count 1,0,1,0…; done every 2nd tick; busy stays 1. With COUNTDOWN_CTRL_RELOAD_CNT_EN, reload_cnt increments per done.
- Pause/handshake: pause for 5 cycles in RUN → count and prescaler frozen, no tick; load_valid held during RUN → load_ready=0, load accepted only after DONE.
- Corners:
  - load 0 → done on first tick.
  - load and start in the same ARMED cycle → stays ARMED with the new value.
  - prescale lowered from 10 to 2 while the prescaler holds 6 → tick next cycle.
